// File: rtl/aespim_accelerator.sv
`timescale 1ns/1ps
// aespim_accelerator: AES-128 key-expansion engine, one FIPS-197 schedule word per command
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   start_i     command valid
//   op_code_i   000 load, 010 expand with g(), 011 expand plain, 001 key readback (optional)
//   data_in_i   key word for load, slot index [1:0] for readback
//   data_out_o  combinational preview of the next word, else last committed word
//   done_o      registered pulse one cycle after each accepted command
// Optional: define AESPIM_KEY_READBACK_EN to enable opcode 001 readback.
module aespim_accelerator (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  op_code_i,
    input  logic [31:0] data_in_i,
    output logic [31:0] data_out_o,
    output logic        done_o
);
    localparam logic [2:0] OP_LD = 3'b000;
    localparam logic [2:0] OP_KEX_FIRST = 3'b010;
    localparam logic [2:0] OP_KEX_NEXT = 3'b011;
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16};

    logic [3:0][31:0] slot;
    logic [1:0]       ld_ptr, p;
    logic [7:0]       rcon;
    logic [31:0]      last_q, oldest, newest, rot, g, cand;
    logic             done_q, is_first, is_next, is_kex, is_ld, is_rd, valid_op;

`ifdef AESPIM_KEY_READBACK_EN
    assign is_rd = op_code_i == 3'b001;
`else
    assign is_rd = 1'b0;
`endif

    // The ring buffer always holds the last four schedule words; slot[p] is
    // w[i-4] and the slot just before it is w[i-1].
    always_comb begin
        is_ld      = op_code_i == OP_LD;
        is_first   = op_code_i == OP_KEX_FIRST;
        is_next    = op_code_i == OP_KEX_NEXT;
        is_kex     = is_first || is_next;
        valid_op   = is_ld || is_kex || is_rd;
        oldest     = slot[p];
        newest     = slot[p - 2'd1];
        rot        = {newest[23:0], newest[31:24]};
        g          = {SBOX[rot[31:24]] ^ rcon, SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
        cand       = is_first ? oldest ^ g : oldest ^ newest;
        data_out_o = is_kex ? cand : is_rd ? slot[data_in_i[1:0]] : last_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot   <= '0;
            ld_ptr <= 2'd0;
            p      <= 2'd1;
            rcon   <= 8'h01;
            last_q <= 32'h0;
            done_q <= 1'b0;
        end else begin
            done_q <= start_i && valid_op;
            if (start_i && is_ld) begin
                slot[ld_ptr] <= data_in_i;
                ld_ptr       <= ld_ptr + 2'd1;
                p            <= 2'd1;
                rcon         <= 8'h01;
                last_q       <= data_in_i;
            end else if (start_i && is_kex) begin
                slot[p] <= cand;
                p       <= p + 2'd1;
                last_q  <= cand;
                if (is_first)
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
        end
    end

    assign done_o = done_q;
endmodule

// File: tb/tb_aespim_accelerator.sv
`timescale 1ns/1ps
// tb_aespim_accelerator: directed-vector bench for the AES-128 key-expansion engine
module tb_aespim_accelerator;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_code_i = 3'b000;
    logic [31:0] data_in_i = 32'h0;
    logic [31:0] data_out_o;
    logic        done_o;
    int checks = 0;
    int failures = 0;

    aespim_accelerator dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .op_code_i(op_code_i),
        .data_in_i(data_in_i),
        .data_out_o(data_out_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] d);
        start_i = s;
        op_code_i = op;
        data_in_i = d;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (data_out_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=%h", data_out_o, 32'h0); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done_o); end
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        checks++; if (data_out_o !== 32'h0) begin failures++; $display("FAIL post_reset_data got=%h want=%h", data_out_o, 32'h0); end
        drive(1'b0, 3'b010, 32'h0);
        #1;
        checks++; if (data_out_o !== 32'h62636363) begin failures++; $display("FAIL reset_rcon_preview got=%h want=%h", data_out_o, 32'h62636363); end
        drive(1'b0, 3'b000, 32'h0);
        tick();
    endtask

    task automatic test_load();
        logic [31:0] k [4];
        k = '{32'h09cf4f3c, 32'h2b7e1516, 32'h28aed2a6, 32'habf71588};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b000, k[i]);
            tick();
            checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL load_done[%0d] got=%b want=1", i, done_o); end
            checks++; if (data_out_o !== k[i]) begin failures++; $display("FAIL load_data[%0d] got=%h want=%h", i, data_out_o, k[i]); end
        end
        drive(1'b0, 3'b000, 32'h0);
        tick();
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL load_idle_done got=%b want=0", done_o); end
    endtask

    task automatic test_first_word();
        drive(1'b0, 3'b010, 32'h0);
        #1;
        checks++; if (data_out_o !== 32'ha0fafe17) begin failures++; $display("FAIL first_preview got=%h want=%h", data_out_o, 32'ha0fafe17); end
        tick();
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL first_hold_done got=%b want=0", done_o); end
        checks++; if (data_out_o !== 32'ha0fafe17) begin failures++; $display("FAIL first_hold_data got=%h want=%h", data_out_o, 32'ha0fafe17); end
        drive(1'b1, 3'b010, 32'h0);
        tick();
        drive(1'b0, 3'b000, 32'h0);
        #1;
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL first_commit_done got=%b want=1", done_o); end
        checks++; if (data_out_o !== 32'ha0fafe17) begin failures++; $display("FAIL first_commit_data got=%h want=%h", data_out_o, 32'ha0fafe17); end
    endtask

    task automatic test_round1();
        logic [31:0] e [3];
        e = '{32'h88542cb1, 32'h23a33939, 32'h2a6c7605};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b011, 32'h0);
            #1;
            checks++; if (data_out_o !== e[i]) begin failures++; $display("FAIL r1_preview[%0d] got=%h want=%h", i, data_out_o, e[i]); end
            tick();
            checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL r1_done[%0d] got=%b want=1", i, done_o); end
        end
        drive(1'b0, 3'b000, 32'h0);
        #1;
        checks++; if (data_out_o !== 32'h2a6c7605) begin failures++; $display("FAIL r1_last got=%h want=%h", data_out_o, 32'h2a6c7605); end
    endtask

    task automatic test_back_to_back_round2();
        logic [31:0] e [4];
        logic [2:0] o [4];
        e = '{32'hf2c295f2, 32'h7a96b943, 32'h5935807a, 32'h7359f67f};
        o = '{3'b010, 3'b011, 3'b011, 3'b011};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, o[i], 32'h0);
            #1;
            checks++; if (data_out_o !== e[i]) begin failures++; $display("FAIL r2_preview[%0d] got=%h want=%h", i, data_out_o, e[i]); end
            tick();
            checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL r2_done[%0d] got=%b want=1", i, done_o); end
        end
        drive(1'b0, 3'b000, 32'h0);
        #1;
        checks++; if (data_out_o !== 32'h7359f67f) begin failures++; $display("FAIL r2_last got=%h want=%h", data_out_o, 32'h7359f67f); end
    endtask

    task automatic test_reserved();
        logic [2:0] o [4];
        o = '{3'b100, 3'b101, 3'b110, 3'b111};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, o[i], 32'hdeadbeef);
            #1;
            checks++; if (data_out_o !== 32'h7359f67f) begin failures++; $display("FAIL rsv_data[%0d] got=%h want=%h", i, data_out_o, 32'h7359f67f); end
            tick();
            checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rsv_done[%0d] got=%b want=0", i, done_o); end
        end
        drive(1'b0, 3'b011, 32'h0);
        #1;
        checks++; if (data_out_o !== 32'h819b638d) begin failures++; $display("FAIL rsv_state got=%h want=%h", data_out_o, 32'h819b638d); end
        drive(1'b0, 3'b000, 32'h0);
        tick();
    endtask

    task automatic test_readback();
        logic [31:0] k [4];
        logic [31:0] e1, e2;
        logic ed;
        k = '{32'h09cf4f3c, 32'h2b7e1516, 32'h28aed2a6, 32'habf71588};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b000, k[i]);
            tick();
        end
`ifdef AESPIM_KEY_READBACK_EN
        e1 = 32'h2b7e1516;
        e2 = 32'h28aed2a6;
        ed = 1'b1;
`else
        e1 = 32'habf71588;
        e2 = 32'habf71588;
        ed = 1'b0;
`endif
        drive(1'b1, 3'b001, 32'h1);
        #1;
        checks++; if (data_out_o !== e1) begin failures++; $display("FAIL rdk_data1 got=%h want=%h", data_out_o, e1); end
        tick();
        checks++; if (done_o !== ed) begin failures++; $display("FAIL rdk_done got=%b want=%b", done_o, ed); end
        drive(1'b0, 3'b001, 32'h2);
        #1;
        checks++; if (data_out_o !== e2) begin failures++; $display("FAIL rdk_data2 got=%h want=%h", data_out_o, e2); end
        drive(1'b0, 3'b010, 32'h0);
        #1;
        checks++; if (data_out_o !== 32'ha0fafe17) begin failures++; $display("FAIL reload_preview got=%h want=%h", data_out_o, 32'ha0fafe17); end
        drive(1'b1, 3'b010, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'b000, 32'h12345678);
        tick();
        checks++; if (data_out_o !== 32'h12345678) begin failures++; $display("FAIL mid_pre_data got=%h want=%h", data_out_o, 32'h12345678); end
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if (data_out_o !== 32'h0) begin failures++; $display("FAIL mid_rst_data got=%h want=%h", data_out_o, 32'h0); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b want=0", done_o); end
        tick();
        rst_i = 1'b0;
        drive(1'b0, 3'b010, 32'h0);
        #1;
        checks++; if (data_out_o !== 32'h62636363) begin failures++; $display("FAIL mid_rst_preview got=%h want=%h", data_out_o, 32'h62636363); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL mid_rst_after_done got=%b want=0", done_o); end
        drive(1'b0, 3'b000, 32'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_first_word();
        test_round1();
        test_back_to_back_round2();
        test_reserved();
        test_readback();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aespim_accelerator.md
Name: aespim_accelerator

Overview:
- Single-cycle-per-word AES-128 key-expansion engine for the aespim processing-in-memory accelerator.
- Software loads the four cipher-key words over a 32-bit command port.
- It then issues key-expansion commands; each command produces the next FIPS-197 schedule word w[i].
- The result is visible combinationally on data_out_o and is committed on the clock edge.

Parameters:
- None. Word width is fixed at 32 bits; key size is fixed at AES-128.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-high; clears all state.
- start_i  in  1  command valid; a command is accepted on each rising edge where start_i=1.
- op_code_i  in  3  command: 000 OP_LD, 010 OP_KEX_FIRST, 011 OP_KEX_NEXT; all others reserved.
- data_in_i  in  32  key word for OP_LD; ignored by the other commands.
- data_out_o  out  32  schedule word (preview or last committed word, see Behaviour).
- done_o  out  1  registered one-cycle pulse after each accepted non-reserved command.

Behaviour:
- State:
  - slot[0..3]: 4x32 ring buffer.
  - ld_ptr: 2 bits.
  - p: 2 bits, expansion pointer.
  - rcon: 8 bits.
  - last_q: 32 bits.
  - done_q: 1 bit.
- Reset values: slot=0, ld_ptr=0, p=1, rcon=8'h01, last_q=0, done_q=0. Therefore data_out_o=0 and done_o=0 during reset.
- Load convention: the first OP_LD carries key word w3; the next three carry w0, w1, w2.
- OP_LD (accepted): slot[ld_ptr]<=data_in_i; ld_ptr<=ld_ptr+1 (wraps); p<=1; rcon<=8'h01; last_q<=data_in_i.
- Expansion operands: oldest = slot[p]; newest = slot[p-1 mod 4].
- g(x) = SubWord(RotWord(x)) ^ {rcon,24'h0}.
  - RotWord: {x[23:0],x[31:24]}.
  - SubWord: the AES S-box applied to each byte.
- cand (combinational):
  - oldest ^ g(newest) when op_code_i=010.
  - oldest ^ newest when op_code_i=011.
- OP_KEX_FIRST/NEXT (accepted): slot[p]<=cand; p<=p+1 (wraps); last_q<=cand.
- OP_KEX_FIRST additionally sets rcon<=xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 8'h1B : 0).
- data_out_o is combinational:
  - equals cand whenever op_code_i is 010 or 011, whether or not start_i is asserted (zero-latency preview);
  - otherwise equals last_q.
- done_q <= start_i and op_code_i is non-reserved. done_o = done_q.
- Reserved opcodes with start_i=1 change no state and do not raise done_o.
- start_i=0 holds all state.
- Commands may be issued back-to-back every cycle; no backpressure exists.
- Software sequencing per round: one OP_KEX_FIRST, then three OP_KEX_NEXT. Other orders are legal and compute the defined formulas without checking.
- A new OP_LD sequence at any time restarts the schedule. Four OP_LDs are needed for a valid key; ld_ptr is not reset by expansion.
- Reset asserted mid-sequence returns every register to its reset value immediately.
- S-box: four combinational 256-entry lookup tables; no pipelining.

Optional Feature:
- Macro AESPIM_KEY_READBACK_EN.
- When defined: opcode 001 is OP_RDK.
  - data_out_o combinationally shows slot[data_in_i[1:0]].
  - An accepted OP_RDK pulses done_o and changes no other state.
- When undefined: 001 is reserved (no state change, no done_o, data_out_o=last_q).

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> data_out_o=0 and done_o=0 immediately; after release, p=1 and rcon=01.
- Load: issue OP_LD 09cf4f3c, 2b7e1516, 28aed2a6, abf71588 back-to-back -> done_o pulses each cycle; data_out_o=abf71588 after the last load.
- First word: op=010 held with start_i=0 -> data_out_o=a0fafe17 before any edge; start_i=1 plus one edge commits it.
- Round 1: three OP_KEX_NEXT -> previews 88542cb1, 23a33939, 2a6c7605; after the final edge with op=000 idle, data_out_o=2a6c7605.
- Round 2 with rcon wrap: continue with 010 then 011 x3 -> f2c295f2, 7a96b943, 5935807a, 7359f67f. Reserved opcode 111 with start_i=1 -> no done_o, no state change.
- With AESPIM_KEY_READBACK_EN, after load: OP_RDK data_in=1 -> data_out_o=2b7e1516. Without the macro -> data_out_o=last_q and no done_o.
